// File: rtl/hub75_pkg.sv
// Shared HUB75 panel geometry, pixel word layout and frame sender state encoding.
package hub75_pkg;

  localparam int PANEL_WIDTH  = 64;
  localparam int PANEL_HEIGHT = 32;
  localparam int PIXEL_BITS   = 16;

  localparam int RED_MSB   = 15;
  localparam int RED_LSB   = 12;
  localparam int GREEN_MSB = 11;
  localparam int GREEN_LSB = 8;
  localparam int BLUE_MSB  = 7;
  localparam int BLUE_LSB  = 4;

  localparam int FRAME_WORDS = PANEL_WIDTH * PANEL_HEIGHT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } sender_state_t;

endpackage

// File: rtl/spi_shift_out.sv
// SPI mode-0 word shifter: half-period divider, low/high phasing and bit counter.
// Runs only while the frame FSM holds run high; load restarts a fresh word MSB first.
module spi_shift_out #(
  parameter int WORD_BITS = 16,
  parameter int CLK_DIV   = 2
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] word,
  input  logic                 run,
  input  logic                 clear,
  output logic                 half_done,
  output logic                 bit_done,
  output logic                 word_done,
  output logic                 spi_clk,
  output logic                 spi_mosi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WORD_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [WORD_BITS-2:0] shreg;

  assign half_done = run && (div_cnt == '0);
  assign bit_done  = half_done && spi_clk;
  assign word_done = bit_done && (bit_idx == '0);

  // MSB goes straight to spi_mosi at load, so the shift register holds only the remaining bits.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else if (load) begin
      div_cnt  <= DIV_LAST;
      bit_idx  <= BIT_LAST;
      shreg    <= word[WORD_BITS-2:0];
      spi_mosi <= word[WORD_BITS-1];
      spi_clk  <= 1'b0;
    end else if (clear) begin
      spi_mosi <= 1'b0;
    end else if (run) begin
      if (div_cnt != '0) begin
        div_cnt <= div_cnt - 1'b1;
      end else begin
        div_cnt <= DIV_LAST;
        spi_clk <= ~spi_clk;
        if (spi_clk && (bit_idx != '0)) begin
          bit_idx  <= bit_idx - 1'b1;
          spi_mosi <= shreg[WORD_BITS-2];
          shreg    <= {shreg[WORD_BITS-3:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_frame_sender.sv
// Streams one framebuffer from a 1-cycle-latency RAM out over a chip-select-less SPI link.
// state | meaning
// IDLE  | waiting for start
// FETCH | RAM read strobe for word_idx
// LOAD  | capture RAM data into the shifter
// LOW   | spi_clk low half-period
// HIGH  | spi_clk high half-period
// DONE  | one-cycle done pulse
module spi_frame_sender
  import hub75_pkg::*;
#(
  parameter int WIDTH      = PANEL_WIDTH,
  parameter int HEIGHT     = PANEL_HEIGHT,
  parameter int WORD_BITS  = PIXEL_BITS,
  parameter int ADDR_WIDTH = 11,
  parameter int CLK_DIV    = 2
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [WORD_BITS-1:0]  mem_data,
  output logic                  spi_clk,
  output logic                  spi_mosi
);

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(WIDTH * HEIGHT - 1);

  sender_state_t         state, state_nxt;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  load, run, clear;
  logic                  half_done, bit_done, word_done;
  logic                  last_word;

  assign last_word = (word_idx == LAST_WORD);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      word_idx <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_HIGH) && word_done && !last_word)
        word_idx <= word_idx + 1'b1;
      else if ((state == ST_IDLE) || (state == ST_DONE))
        word_idx <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    run       = 1'b0;
    clear     = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD: begin
        load      = 1'b1;
        state_nxt = ST_LOW;
      end
      ST_LOW: begin
        run = 1'b1;
        if (half_done) state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        run = 1'b1;
        if (bit_done) begin
          if (!word_done)    state_nxt = ST_LOW;
          else if (last_word) state_nxt = ST_DONE;
          else               state_nxt = ST_FETCH;
        end
      end
      ST_DONE: begin
        clear     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign mem_rd_en = (state == ST_FETCH);
  assign mem_addr  = word_idx;

  spi_shift_out #(
    .WORD_BITS (WORD_BITS),
    .CLK_DIV   (CLK_DIV)
  ) u_shift (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .load      (load),
    .word      (mem_data),
    .run       (run),
    .clear     (clear),
    .half_done (half_done),
    .bit_done  (bit_done),
    .word_done (word_done),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi)
  );

endmodule

// File: tb/tb_spi_frame_sender.sv
// Scoreboard bench: an SPI slave model rebuilds words on spi_clk rises and checks them against RAM snapshots.
module tb_spi_frame_sender;

  localparam int WIDTH      = 8;
  localparam int HEIGHT     = 4;
  localparam int WORD_BITS  = 16;
  localparam int ADDR_WIDTH = 5;
  localparam int CLK_DIV    = 2;
  localparam int FW         = WIDTH * HEIGHT;
  localparam int WORD_CYC   = 2 * CLK_DIV * WORD_BITS + 2;
  localparam int FRAME_BOUND = FW * WORD_CYC + 50;

  logic                  sys_clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  busy, done, mem_rd_en, spi_clk, spi_mosi;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_BITS-1:0]  mem_data = '0;
  logic [WORD_BITS-1:0]  ram [FW];

  int n_checks = 0;
  int n_fail   = 0;
  logic [WORD_BITS-1:0] exp_q [$];
  int edges = 0, words_rx = 0, done_cnt = 0, slave_bits = 0, busy_drops = 0;
  logic [WORD_BITS-1:0] slave_sr = '0;
  logic prev_done = 1'b0;
  bit   busy_watch = 1'b0;

  spi_frame_sender #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .WORD_BITS(WORD_BITS),
    .ADDR_WIDTH(ADDR_WIDTH), .CLK_DIV(CLK_DIV)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) if (mem_rd_en) mem_data <= ram[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // SPI slave model: sample on rising spi_clk, a word every WORD_BITS edges.
  always @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      slave_bits = 0;
      exp_q.delete();
    end else begin
      edges++;
      slave_sr = {slave_sr[WORD_BITS-2:0], spi_mosi};
      slave_bits++;
      if (slave_bits == WORD_BITS) begin
        slave_bits = 0;
        words_rx++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", slave_sr);
        end else begin
          check("word", 32'(slave_sr), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (done) begin
      done_cnt++;
      check("done_width", 32'(prev_done), 0);
      check("done_all_words", 32'(exp_q.size()), 0);
      check("done_word_align", 32'(slave_bits), 0);
      check("done_busy", 32'(busy), 1);
    end
    if (busy_watch && !busy) busy_drops++;
    prev_done = done;
  end

  task automatic start_frame();
    for (int i = 0; i < FW; i++) exp_q.push_back(ram[i]);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < FRAME_BOUND) begin
      @(negedge sys_clk);
      t++;
    end
    check({name, "_done_seen"}, 32'(done), 1);
    @(negedge sys_clk);
  endtask

  task automatic fill_bars();
    for (int i = 0; i < FW; i++) begin
      int bar;
      logic [3:0] lvl;
      bar = ((i % WIDTH) * 8) / WIDTH;
      lvl = 4'($urandom_range(1, 15));
      ram[i] = {(bar & 1) != 0 ? lvl : 4'h0, (bar & 2) != 0 ? lvl : 4'h0,
                (bar & 4) != 0 ? lvl : 4'h0, 4'h0};
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0, w0, t;
    for (int i = 0; i < FW; i++) ram[i] = WORD_BITS'($urandom) & 16'hFFF0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      check("idle_outputs", {27'd0, spi_clk, spi_mosi, busy, done, mem_rd_en}, 0);
    end
    check("idle_addr", 32'(mem_addr), 0);

    // Single frame with 0xF000 first, plus start latency.
    ram[0] = 16'hF000;
    e0 = edges; d0 = done_cnt; w0 = words_rx;
    check("busy_before_accept", 32'(busy), 0);
    start_frame();
    check("fetch_rd_en", 32'(mem_rd_en), 1);
    check("fetch_addr", 32'(mem_addr), 0);
    check("fetch_busy", 32'(busy), 1);
    for (int k = 1; k <= 2 + CLK_DIV; k++) begin
      @(negedge sys_clk);
      if (k == 1) check("load_rd_en", 32'(mem_rd_en), 0);
      check("first_rise_time", 32'(spi_clk), (k == 2 + CLK_DIV) ? 1 : 0);
    end
    wait_done("frame1");
    check("frame1_edges", 32'(edges - e0), 32'(FW * WORD_BITS));
    check("frame1_words", 32'(words_rx - w0), 32'(FW));
    check("frame1_done", 32'(done_cnt - d0), 1);
    check("frame1_idle", 32'(busy), 0);

    // Back-to-back test-bar frames.
    fill_bars();
    e0 = edges; d0 = done_cnt;
    start_frame();
    wait_done("b2b_a");
    start_frame();
    wait_done("b2b_b");
    check("b2b_edges", 32'(edges - e0), 32'(2 * FW * WORD_BITS));
    check("b2b_done", 32'(done_cnt - d0), 2);

    // start pulsed mid-frame is ignored and not queued.
    for (int i = 0; i < FW; i++) ram[i] = WORD_BITS'($urandom) & 16'hFFF0;
    e0 = edges; d0 = done_cnt; w0 = words_rx; busy_drops = 0;
    start_frame();
    busy_watch = 1'b1;
    t = 0;
    while (words_rx - w0 < 10 && t < FRAME_BOUND) begin
      @(negedge sys_clk);
      t++;
    end
    check("midstart_reach_word", 32'(words_rx - w0 >= 10), 1);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_done("midstart");
    busy_watch = 1'b0;
    check("midstart_busy_drops", 32'(busy_drops), 0);
    repeat (2 * WORD_CYC) @(negedge sys_clk);
    check("midstart_edges", 32'(edges - e0), 32'(FW * WORD_BITS));
    check("midstart_done", 32'(done_cnt - d0), 1);
    check("midstart_not_queued", 32'(busy), 0);

    // Async reset mid-bit, then a clean restart from address 0.
    for (int i = 0; i < FW; i++) ram[i] = WORD_BITS'($urandom) & 16'hFFF0;
    w0 = words_rx; d0 = done_cnt;
    start_frame();
    t = 0;
    while ((words_rx - w0 < 20 || !spi_clk) && t < FRAME_BOUND) begin
      @(negedge sys_clk);
      t++;
    end
    check("reset_reach_word", 32'(spi_clk), 1);
    #2 reset = 1'b1;
    #1;
    check("reset_async_clk", 32'(spi_clk), 0);
    check("reset_async_mosi", 32'(spi_mosi), 0);
    check("reset_async_busy", 32'(busy), 0);
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    check("reset_no_done", 32'(done_cnt - d0), 0);
    e0 = edges;
    start_frame();
    check("restart_rd_en", 32'(mem_rd_en), 1);
    check("restart_addr", 32'(mem_addr), 0);
    wait_done("restart");
    check("restart_edges", 32'(edges - e0), 32'(FW * WORD_BITS));
    check("restart_done", 32'(done_cnt - d0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
